// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared definitions for the two-requester I2C bus arbiter: FSM state encoding,
// requester indices and a small grant-encoding helper.
package i2c_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        ACTIVE,
        FORCE_STOP,
        GAP
    } arb_state_e;

    localparam int REQ_ALT = 0;
    localparam int REQ_IMU = 1;

    function automatic logic [1:0] onehot2(input logic idx);
        return (idx == 1'(REQ_ALT)) ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter multiplexing two requesters (altimeter, IMU) onto one shared
// I2C driver, with stall timeout, forced stop and an enforced bus-free gap.
module i2c_bus_arbiter
    import i2c_bus_arbiter_pkg::*;
#(
    parameter int GAP_CYCLES = 50,
    parameter int TIMEOUT    = 65535,
    parameter int TO_W       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    output logic [1:0]  gnt,
    input  logic [1:0]  ena_i,
    input  logic [1:0]  rw_i,
    input  logic [1:0]  start_transfer_i,
    input  logic [1:0]  stop_transfer_i,
    input  logic [1:0]  r_start_i,
    input  logic [15:0] data_wr_i,
    output logic [1:0]  busy_o,
    output logic [1:0]  ready_o,
    output logic [1:0]  ack_err_o,
    output logic [7:0]  data_rd_o,
    output logic        m_ena,
    output logic        m_rw,
    output logic        m_start_transfer,
    output logic        m_stop_transfer,
    output logic        m_r_start,
    output logic [7:0]  m_data_wr,
    input  logic        m_busy,
    input  logic        m_ready,
    input  logic        m_ack_err,
    input  logic [7:0]  m_data_rd,
    output logic        timeout_err
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    arb_state_e        state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              owner_q, owner_d;
    logic              ptr_q, ptr_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic              armed_q, armed_d;

    logic pick;
    logic g_req, g_ena, g_start, g_stop;

    // Contention is resolved by the pointer; a lone request wins outright.
    assign pick    = (req[0] && req[1]) ? ptr_q : req[1];
    assign g_req   = req[owner_q];
    assign g_ena   = ena_i[owner_q];
    assign g_start = start_transfer_i[owner_q];
    assign g_stop  = stop_transfer_i[owner_q];

    assign gnt       = gnt_q;
    assign data_rd_o = m_data_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= 2'b00;
            owner_q   <= 1'(REQ_ALT);
            ptr_q     <= 1'(REQ_ALT);
            to_cnt_q  <= '0;
            gap_cnt_q <= '0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            to_cnt_q  <= to_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            armed_q   <= armed_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        gnt_d            = gnt_q;
        owner_d          = owner_q;
        ptr_d            = ptr_q;
        to_cnt_d         = '0;
        gap_cnt_d        = '0;
        armed_d          = 1'b0;
        m_ena            = 1'b0;
        m_rw             = 1'b0;
        m_start_transfer = 1'b0;
        m_stop_transfer  = 1'b0;
        m_r_start        = 1'b0;
        m_data_wr        = 8'h00;
        busy_o           = 2'b11;
        ready_o          = 2'b00;
        ack_err_o        = 2'b00;
        timeout_err      = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    owner_d = pick;
                    gnt_d   = onehot2(pick);
                end
            end
            GRANT: begin
                if (g_start) begin
                    state_d = ACTIVE;
                end else if (!g_req) begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                end
            end
            ACTIVE: begin
                armed_d = armed_q | g_stop;
                if (m_busy || g_ena)
                    to_cnt_d = '0;
                else if (to_cnt_q != '1)
                    to_cnt_d = to_cnt_q + 1'b1;
                else
                    to_cnt_d = to_cnt_q;
                // Release takes priority over a coincident timeout.
                if (armed_q && !m_busy) begin
                    state_d = GAP;
                    gnt_d   = 2'b00;
                    ptr_d   = ~owner_q;
                    armed_d = 1'b0;
                end else if (to_cnt_d == TO_W'(TIMEOUT)) begin
                    state_d = FORCE_STOP;
                    gnt_d   = 2'b00;
                    armed_d = 1'b0;
                end
            end
            FORCE_STOP: begin
                state_d         = GAP;
                ptr_d           = ~owner_q;
                m_stop_transfer = 1'b1;
                timeout_err     = 1'b1;
            end
            GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1))
                    state_d = IDLE;
                else
                    gap_cnt_d = gap_cnt_q + 1'b1;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
        endcase

        if (|gnt_q) begin
            m_ena              = g_ena;
            m_rw               = rw_i[owner_q];
            m_start_transfer   = g_start;
            m_stop_transfer    = g_stop;
            m_r_start          = r_start_i[owner_q];
            m_data_wr          = (owner_q == 1'(REQ_IMU)) ? data_wr_i[15:8] : data_wr_i[7:0];
            busy_o[owner_q]    = m_busy;
            ready_o[owner_q]   = m_ready;
            ack_err_o[owner_q] = m_ack_err;
        end
    end

endmodule

// File: doc/i2c_bus_arbiter.md
I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 Parameters SHALL be: GAP_CYCLES, default 50, bus-free cycles between grants; TIMEOUT, default 65535, idle-lock cycles before forced release; TO_W, default 16, timeout counter width.
REQ-002 Port clk SHALL be: input, width 1, system clock; one clock domain only.
REQ-003 Port rst SHALL be: input, width 1, reset; synchronous and active-high.
REQ-004 Port req SHALL be: input, width 2, bus request per requester; bit0 altimeter, bit1 IMU.
REQ-005 Port gnt SHALL be: output, width 2, one-hot-or-zero grant.
REQ-006 Ports ena_i, rw_i, start_transfer_i, stop_transfer_i, r_start_i SHALL be: inputs, width 2 each, per-requester driver controls.
REQ-007 Port data_wr_i SHALL be: input, width 16, {req1[7:0], req0[7:0]}.
REQ-008 Ports busy_o, ready_o, ack_err_o SHALL be: outputs, width 2 each, per-requester driver status.
REQ-009 Port data_rd_o SHALL be: output, width 8, read byte broadcast to both requesters.
REQ-010 Ports m_ena, m_rw, m_start_transfer, m_stop_transfer, m_r_start SHALL be: outputs, width 1 each, to the shared I2C_Driver.
REQ-011 Port m_data_wr SHALL be: output, width 8, to the shared I2C_Driver.
REQ-012 Ports m_busy, m_ready, m_ack_err SHALL be: inputs, width 1 each, from the shared I2C_Driver.
REQ-013 Port m_data_rd SHALL be: input, width 8, from the shared I2C_Driver.
REQ-014 Port timeout_err SHALL be: output, width 1, one-cycle pulse on forced release.

Function
REQ-015 FSM states SHALL be IDLE, GRANT, ACTIVE, FORCE_STOP, GAP.
REQ-016 IDLE: any req bit high -> GRANT next cycle; gnt registered, high the cycle after req is sampled.
REQ-017 Selection SHALL be round-robin: on simultaneous requests, the requester not granted last wins; after reset, requester 0 wins.
REQ-018 While a grant is held, m_* controls and m_data_wr SHALL be combinational muxes of the granted requester's inputs; with no grant all m_* SHALL be 0.
REQ-019 Granted requester SHALL receive m_busy, m_ready and m_ack_err directly.
REQ-020 Non-granted requesters SHALL see busy_o=1, ready_o=0, ack_err_o=0.
REQ-021 GRANT: granted start_transfer_i high -> ACTIVE; granted req low before start -> IDLE, no gap.
REQ-022 ACTIVE: stop_transfer_i from granted requester SHALL arm release; exit to GAP the first cycle after the arm with m_busy=0.
REQ-023 Grant SHALL hold through ACTIVE regardless of req, so repeated-start sequences (r_start) are never split between requesters.
REQ-024 Timeout counter SHALL clear on any cycle in ACTIVE with m_busy=1 or granted ena_i=1; otherwise it increments, saturating.
REQ-025 Counter reaching TIMEOUT SHALL cause FORCE_STOP: one cycle of m_stop_transfer=1, m_ena=0, gnt=0, timeout_err=1, then GAP.
REQ-026 GAP: gnt=0, m_* =0 for exactly GAP_CYCLES cycles, then IDLE; the round-robin pointer updates on GAP entry.
REQ-027 A requester dropping req while in ACTIVE SHALL NOT cut the transaction short; stop or timeout is the only exit.
REQ-028 data_rd_o SHALL equal m_data_rd at all times.

Reset
REQ-029 On rst: state=IDLE, gnt=0, all m_* =0, timeout_err=0, counters=0, pointer=requester 0, busy_o=2'b11, ready_o=0, ack_err_o=0.
REQ-030 Reset mid-ACTIVE SHALL drop the grant immediately; the I2C_Driver shares rst and recovers itself, so no stop is issued.

Structure
REQ-031 Shared package SHALL hold the state enum and the requester index constants REQ_ALT=0 and REQ_IMU=1.
REQ-032 There SHALL be no sub-module; the two-way round-robin pick is inline logic.

Verification
REQ-033 Single request: req=01 at cycle 0 -> gnt=01 at cycle 1; data_wr_i[7:0]=0xEE appears on m_data_wr; busy_o[1]=1 throughout.
REQ-034 Simultaneous requests after reset: req=11 -> gnt=01 first; after stop and 50 GAP cycles, gnt=10; next contention -> gnt=01.
REQ-035 Repeated start: requester 1 issues start, r_start, and 6 read bytes (0x11..0x16) while req0 is held high -> no grant change until stop; all 6 bytes seen on data_rd_o.
REQ-036 Timeout with TIMEOUT=100: requester issues start and then stalls -> at 100 idle cycles, m_stop_transfer and timeout_err pulse for 1 cycle, gnt=00, GAP entered.
REQ-037 Abort before start: req0 raised then dropped in GRANT -> IDLE next cycle, no GAP; a pending req1 is granted 1 cycle later.
REQ-038 Reset mid-ACTIVE: rst for 1 cycle -> next cycle gnt=00, m_ena=0, busy_o=11; next contention grants requester 0.
